if_prefetch_unit: RTL and testbench
===================================

// Module: if_prefetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage; successor to the single-register fetch unit. Decouples PC
//  generation from decode through a DEPTH-entry prefetch queue of {pc, instr}. Adds N prioritised
//  interrupt vectors, flush on redirect, and trap-handler instruction injection. Sits between the
//  instruction memory interface and IFID.
// PARAMETERS
//  ADDR_W    16       PC / fetch address width
//  INSTR_W   32       instruction width
//  DEPTH     4        prefetch queue entries (power of 2, >=2)
//  NUM_IRQ   3        interrupt sources; index 0 = highest priority
//  RESET_PC  'h0000   PC after reset
//  VEC_BASE  'h03FD   ISR vector for irq i = VEC_BASE + i
//  BUBBLE    all-1s   instruction emitted when no valid instruction is available
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous, active-high reset
//  imem_req      out  1        fetch request this cycle
//  imem_addr     out  ADDR_W   fetch address (= fetch_pc)
//  imem_rdata    in   INSTR_W  read data, valid exactly 1 cycle after imem_req
//  stall         in   1        decode not accepting; head held
//  redirect      in   1        branch/jump taken
//  redirect_pc   in   ADDR_W   target PC
//  irq_req       in   NUM_IRQ  level interrupt requests
//  irq_en        in   1        global interrupt enable
//  irq_ack       out  NUM_IRQ  one-hot, 1-cycle pulse on vector entry
//  epc           out  ADDR_W   PC to resume after the ISR, latched on entry
//  inject_valid  in   1        trap handler injects inject_instr ahead of the queue
//  inject_instr  in   INSTR_W  injected instruction
//  out_valid     out  1        out_instr is a real instruction
//  out_instr     out  INSTR_W  to IFID (BUBBLE when !out_valid)
//  out_pc        out  ADDR_W   PC of out_instr
//  out_pc_plus1  out  ADDR_W   out_pc + 1, modulo 2^ADDR_W
//  keep_flags    out  1        = inject_valid
// BEHAVIOUR
//  Reset: fetch_pc=RESET_PC, queue empty, epoch=0, state=RUN; imem_req=0, irq_ack=0, epc=0,
//   out_valid=0, out_instr=BUBBLE, out_pc=RESET_PC, out_pc_plus1=RESET_PC+1.
//  Issue: imem_req=1 when state==RUN && (count + inflight) < DEPTH && !redirect; fetch_pc++ per issue.
//  Response: one cycle later, push {issued_pc, imem_rdata} if the tag epoch equals the current
//   epoch; otherwise drop it.
//  Output (combinational from head): inject_valid selects inject_instr with out_valid=1,
//   out_pc=head pc, no pop. Otherwise out_valid = !empty. Pop when out_valid && !stall && !inject_valid.
//  Priority, same cycle: rst > redirect > interrupt entry > issue/pop.
//  Redirect: flush queue, toggle epoch, fetch_pc=redirect_pc, imem_req=0 that cycle.
//   Issue resumes next cycle.
//  Interrupt entry when irq_en && |irq_req && state==RUN && !inject_valid:
//   - grant lowest index i; irq_ack[i]=1 for 1 cycle;
//   - epc = head pc if queue non-empty, else fetch_pc (the in-flight pc if one is outstanding);
//   - flush queue, toggle epoch, fetch_pc = VEC_BASE+i, state -> IRQ_HOLD.
//  IRQ_HOLD: one cycle with no issue and out_valid=0 (lets trap handler assert ld_idr/ld_epc
//   via inject_valid); then -> RUN. irq_req is ignored while in IRQ_HOLD.
//  Stall: head and outputs held; issue continues until the queue plus in-flight is full.
//  Full: no issue. Empty: BUBBLE out. PC wraps modulo 2^ADDR_W.
//  Reset mid-flight: the outstanding response is dropped (epoch reset, inflight cleared).
// STRUCTURE
//  Package if_pkg: ADDR_W/INSTR_W defaults, BUBBLE constant, state enum {RUN, IRQ_HOLD},
//   fetch_entry_t {pc, instr}.
//  Sub-module: if_prefetch_fifo (DEPTH, entry width; push/pop/flush, count, head).
//   Same-cycle push+pop on full is legal. Flush wins over push.
//  Top holds fetch_pc, epoch, inflight tag, priority encoder, FSM.
// TESTING
//  1. Reset, stall=0, imem returns addr as data: issue 0,1,2..., out_pc 0,1,2 with a 2-cycle
//     first latency, then 1 per cycle.
//  2. stall=1 for 6 cycles: exactly DEPTH issues, out_pc held at its value, then resume with
//     no loss or duplication.
//  3. redirect to 'h0040 while a response is in flight: stale data dropped; next out_pc='h0040.
//  4. irq_req=3'b110 with head pc 'h0012: irq_ack=3'b010, epc='h0012, next fetch at 'h03FE,
//     one empty cycle.
//  5. inject_valid during IRQ_HOLD and on a stalled head: out_instr=inject_instr, keep_flags=1,
//     queue unchanged.
//  6. redirect and irq in the same cycle: redirect wins, no irq_ack. fetch_pc='hFFFF wraps to 0.

Source files
------------

// File: rtl/if_prefetch_unit_pkg.sv
// Shared types for the instruction-fetch stage.
// Queue entry layout, FSM states and the bubble encoding.
package if_pkg;

    localparam int IF_ADDR_W  = 16;
    localparam int IF_INSTR_W = 32;

    localparam logic [IF_INSTR_W-1:0] BUBBLE = '1;

    typedef enum logic {
        RUN      = 1'b0,
        IRQ_HOLD = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [IF_ADDR_W-1:0]  pc;
        logic [IF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-stage bundle: imem port, decode-side output, redirect,
// interrupt and trap-injection signals.
interface if_prefetch_unit_if
    import if_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter int NUM_IRQ = 3
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               stall;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [NUM_IRQ-1:0] irq_req;
    logic               irq_en;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [ADDR_W-1:0]  epc;
    logic               inject_valid;
    logic [INSTR_W-1:0] inject_instr;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus1;
    logic               keep_flags;

    modport master (
        output imem_rdata, stall, redirect, redirect_pc,
        output irq_req, irq_en, inject_valid, inject_instr,
        input  imem_req, imem_addr, irq_ack, epc,
        input  out_valid, out_instr, out_pc, out_pc_plus1, keep_flags
    );

    modport slave (
        input  imem_rdata, stall, redirect, redirect_pc,
        input  irq_req, irq_en, inject_valid, inject_instr,
        output imem_req, imem_addr, irq_ack, epc,
        output out_valid, out_instr, out_pc, out_pc_plus1, keep_flags
    );

endinterface

// File: rtl/if_prefetch_unit_fifo.sv
// Prefetch queue: power-of-2 ring buffer with flush.
// Push and pop may coincide when full; flush beats push.
module if_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [W-1:0]             head,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem_q[wr_q] <= din;
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: PC generation, epoch-tagged imem
// requests, prefetch queue, vectored interrupts and trap injection.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter int DEPTH   = 4,
    parameter int NUM_IRQ = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'('h03FD)
) (
    input  logic              clk,
    input  logic              rst,
    if_prefetch_unit_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              epoch_q, epoch_d;
    logic              infl_q, infl_d;
    logic              infl_ep_q, infl_ep_d;

    logic [CW-1:0]      count;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;
    logic               empty, push, pop, flush;
    logic               issue, irq_take, found, live_infl, out_v;
    logic [NUM_IRQ-1:0] grant;
    logic [ADDR_W-1:0]  irq_off, cur_pc;

    if_prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .count (count),
        .head  (head),
        .empty (empty)
    );

    // Lowest index wins.
    always_comb begin
        found   = 1'b0;
        grant   = '0;
        irq_off = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.irq_req[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                irq_off  = ADDR_W'(i);
            end
        end
    end

    always_comb begin
        live_infl = infl_q && (infl_ep_q == epoch_q);
        cur_pc    = fetch_pc_q;
        if (!empty)         cur_pc = head.pc;
        else if (live_infl) cur_pc = infl_pc_q;
        irq_take = bus.irq_en && found && (state_q == RUN)
                   && !bus.inject_valid && !bus.redirect;
        issue = !rst && (state_q == RUN) && !bus.redirect && !irq_take
                && (({1'b0, count} + (CW+1)'(infl_q)) < (CW+1)'(DEPTH));
        flush      = bus.redirect || irq_take;
        push       = live_infl;
        push_entry = '{pc: infl_pc_q, instr: bus.imem_rdata};
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        epc_d      = epc_q;
        infl_d     = issue;
        infl_pc_d  = fetch_pc_q;
        infl_ep_d  = epoch_q;
        unique case (1'b1)
            bus.redirect: begin
                fetch_pc_d = bus.redirect_pc;
                epoch_d    = ~epoch_q;
                state_d    = RUN;
            end
            irq_take: begin
                fetch_pc_d = VEC_BASE + irq_off;
                epoch_d    = ~epoch_q;
                epc_d      = cur_pc;
                state_d    = IRQ_HOLD;
            end
            default: begin
                state_d = RUN;
                if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
        endcase
    end

    always_comb begin
        bus.imem_req     = issue;
        bus.imem_addr    = fetch_pc_q;
        bus.irq_ack      = (irq_take && !rst) ? grant : '0;
        bus.epc          = epc_q;
        bus.keep_flags   = bus.inject_valid;
        bus.out_pc       = cur_pc;
        bus.out_pc_plus1 = cur_pc + ADDR_W'(1);
        out_v            = !empty && (state_q == RUN);
        bus.out_valid    = out_v;
        bus.out_instr    = INSTR_W'(BUBBLE);
        if (bus.inject_valid) begin
            bus.out_valid = 1'b1;
            bus.out_instr = bus.inject_instr;
        end else if (out_v) begin
            bus.out_instr = head.instr;
        end
        pop = out_v && !bus.inject_valid && !bus.stall && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            infl_ep_q  <= 1'b0;
            epc_q      <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            infl_q     <= infl_d;
            infl_pc_q  <= infl_pc_d;
            infl_ep_q  <= infl_ep_d;
            epc_q      <= epc_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit; imem returns {C0DE, addr}.
module tb_if_prefetch_unit;
    import if_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    if_prefetch_unit_if bus ();

    if_prefetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? {16'hC0DE, bus.imem_addr} : 32'hDEAD_BEEF;

    task automatic clear_in();
        bus.stall        = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.irq_req      = '0;
        bus.irq_en       = 1'b0;
        bus.inject_valid = 1'b0;
        bus.inject_instr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_run++;
        if (bus.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL rst_req got %b want 0", bus.imem_req);
        end
        n_run++;
        if (bus.irq_ack !== 3'b000 || bus.epc !== 16'h0000) begin
            n_fail++; $display("FAIL rst_irq ack=%b epc=%h want 000/0000", bus.irq_ack, bus.epc);
        end
        n_run++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== BUBBLE) begin
            n_fail++; $display("FAIL rst_out v=%b i=%h want 0/%h", bus.out_valid, bus.out_instr, BUBBLE);
        end
        n_run++;
        if (bus.out_pc !== 16'h0000 || bus.out_pc_plus1 !== 16'h0001) begin
            n_fail++; $display("FAIL rst_pc pc=%h p1=%h want 0000/0001", bus.out_pc, bus.out_pc_plus1);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            n_run++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'(k)) begin
                n_fail++; $display("FAIL stream_issue k=%0d req=%b addr=%h want 1/%h", k, bus.imem_req, bus.imem_addr, 16'(k));
            end
            n_run++;
            if (bus.out_valid !== (k >= 2)) begin
                n_fail++; $display("FAIL stream_valid k=%0d got %b", k, bus.out_valid);
            end
            if (k >= 2) begin
                n_run++;
                if (bus.out_pc !== 16'(k-2) || bus.out_instr !== {16'hC0DE, 16'(k-2)}) begin
                    n_fail++; $display("FAIL stream_out k=%0d pc=%h i=%h want %h", k, bus.out_pc, bus.out_instr, 16'(k-2));
                end
            end else begin
                n_run++;
                if (bus.out_instr !== BUBBLE) begin
                    n_fail++; $display("FAIL stream_bubble k=%0d got %h want %h", k, bus.out_instr, BUBBLE);
                end
            end
        end
    endtask

    task automatic test_stall();
        int nissue;
        nissue = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            bus.stall = (k < 6);
            #1;
            if (k < 6) begin
                if (bus.imem_req === 1'b1) nissue++;
                n_run++;
                if (bus.imem_req !== (k < 4)) begin
                    n_fail++; $display("FAIL stall_req k=%0d got %b want %b", k, bus.imem_req, (k < 4));
                end
                if (k >= 2) begin
                    n_run++;
                    if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0000) begin
                        n_fail++; $display("FAIL stall_hold k=%0d v=%b pc=%h want 1/0000", k, bus.out_valid, bus.out_pc);
                    end
                end
            end else begin
                n_run++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'(k-6)) begin
                    n_fail++; $display("FAIL stall_resume k=%0d v=%b pc=%h want 1/%h", k, bus.out_valid, bus.out_pc, 16'(k-6));
                end
            end
        end
        n_run++;
        if (nissue != 4) begin
            n_fail++; $display("FAIL stall_issues got %0d want 4", nissue);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk);
            bus.redirect    = (k == 4);
            bus.redirect_pc = 16'h0040;
            #1;
            if (k == 4) begin
                n_run++;
                if (bus.imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL redir_req got %b want 0", bus.imem_req);
                end
            end
            if (k == 5) begin
                n_run++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0040 || bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL redir_issue req=%b addr=%h v=%b want 1/0040/0", bus.imem_req, bus.imem_addr, bus.out_valid);
                end
            end
            if (k == 6) begin
                n_run++;
                if (bus.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL redir_gap got %b want 0", bus.out_valid);
                end
            end
            if (k == 7) begin
                n_run++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h0040 || bus.out_instr !== 32'hC0DE_0040) begin
                    n_fail++; $display("FAIL redir_out v=%b pc=%h i=%h want 1/0040/c0de0040", bus.out_valid, bus.out_pc, bus.out_instr);
                end
            end
            if (k == 8) begin
                n_run++;
                if (bus.out_pc !== 16'h0041) begin
                    n_fail++; $display("FAIL redir_next got %h want 0041", bus.out_pc);
                end
            end
        end
    endtask

    task automatic test_irq();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            bus.redirect    = (k == 0);
            bus.redirect_pc = 16'h0012;
            bus.irq_en      = 1'b1;
            bus.irq_req     = (k == 3 || k == 4) ? 3'b110 : 3'b000;
            #1;
            if (k == 3) begin
                n_run++;
                if (bus.irq_ack !== 3'b010 || bus.out_pc !== 16'h0012) begin
                    n_fail++; $display("FAIL irq_ack ack=%b pc=%h want 010/0012", bus.irq_ack, bus.out_pc);
                end
            end
            if (k == 4) begin
                n_run++;
                if (bus.irq_ack !== 3'b000 || bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL irq_hold ack=%b v=%b req=%b want 000/0/0", bus.irq_ack, bus.out_valid, bus.imem_req);
                end
                n_run++;
                if (bus.epc !== 16'h0012) begin
                    n_fail++; $display("FAIL irq_epc got %h want 0012", bus.epc);
                end
            end
            if (k == 5) begin
                n_run++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h03FE) begin
                    n_fail++; $display("FAIL irq_vec req=%b addr=%h want 1/03fe", bus.imem_req, bus.imem_addr);
                end
            end
            if (k == 7) begin
                n_run++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h03FE) begin
                    n_fail++; $display("FAIL irq_out v=%b pc=%h want 1/03fe", bus.out_valid, bus.out_pc);
                end
            end
        end
    endtask

    task automatic test_inject();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            bus.irq_en       = 1'b1;
            bus.irq_req      = (k == 0) ? 3'b001 : 3'b000;
            bus.inject_valid = (k == 1 || k == 4 || k == 5);
            bus.inject_instr = (k == 1) ? 32'h1234_5678 : 32'hAAAA_5555;
            bus.stall        = (k == 4 || k == 5);
            #1;
            if (k == 0) begin
                n_run++;
                if (bus.irq_ack !== 3'b001) begin
                    n_fail++; $display("FAIL inj_ack got %b want 001", bus.irq_ack);
                end
            end
            if (k == 1) begin
                n_run++;
                if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h1234_5678
                    || bus.keep_flags !== 1'b1 || bus.imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL inj_hold v=%b i=%h kf=%b req=%b want 1/12345678/1/0", bus.out_valid, bus.out_instr, bus.keep_flags, bus.imem_req);
                end
            end
            if (k == 2) begin
                n_run++;
                if (bus.keep_flags !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h03FD) begin
                    n_fail++; $display("FAIL inj_vec kf=%b req=%b addr=%h want 0/1/03fd", bus.keep_flags, bus.imem_req, bus.imem_addr);
                end
            end
            if (k == 4 || k == 5) begin
                n_run++;
                if (bus.out_instr !== 32'hAAAA_5555 || bus.out_pc !== 16'h03FD || bus.keep_flags !== 1'b1) begin
                    n_fail++; $display("FAIL inj_stall k=%0d i=%h pc=%h kf=%b want aaaa5555/03fd/1", k, bus.out_instr, bus.out_pc, bus.keep_flags);
                end
            end
            if (k == 6) begin
                n_run++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 16'h03FD || bus.out_instr !== 32'hC0DE_03FD) begin
                    n_fail++; $display("FAIL inj_keep v=%b pc=%h i=%h want 1/03fd/c0de03fd", bus.out_valid, bus.out_pc, bus.out_instr);
                end
            end
            if (k == 7) begin
                n_run++;
                if (bus.out_pc !== 16'h03FE) begin
                    n_fail++; $display("FAIL inj_next got %h want 03fe", bus.out_pc);
                end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            bus.redirect    = (k == 0);
            bus.redirect_pc = 16'hFFFF;
            bus.irq_en      = 1'b1;
            bus.irq_req     = (k == 0) ? 3'b001 : 3'b000;
            #1;
            if (k == 0) begin
                n_run++;
                if (bus.irq_ack !== 3'b000 || bus.imem_req !== 1'b0) begin
                    n_fail++; $display("FAIL wrap_prio ack=%b req=%b want 000/0", bus.irq_ack, bus.imem_req);
                end
            end
            if (k == 1 || k == 2) begin
                n_run++;
                if (bus.imem_req !== 1'b1 || bus.imem_addr !== ((k == 1) ? 16'hFFFF : 16'h0000)) begin
                    n_fail++; $display("FAIL wrap_issue k=%0d req=%b addr=%h", k, bus.imem_req, bus.imem_addr);
                end
            end
            if (k == 3) begin
                n_run++;
                if (bus.out_pc !== 16'hFFFF || bus.out_pc_plus1 !== 16'h0000 || bus.out_instr !== 32'hC0DE_FFFF) begin
                    n_fail++; $display("FAIL wrap_out pc=%h p1=%h i=%h want ffff/0000/c0deffff", bus.out_pc, bus.out_pc_plus1, bus.out_instr);
                end
            end
            if (k == 4) begin
                n_run++;
                if (bus.out_pc !== 16'h0000 || bus.out_pc_plus1 !== 16'h0001) begin
                    n_fail++; $display("FAIL wrap_next pc=%h p1=%h want 0000/0001", bus.out_pc, bus.out_pc_plus1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_irq();
        test_inject();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
